signed_div_sequencer: RTL and testbench

Sequencer for 8-bit signed division built around the shared magnitude/complement unit. It accepts a signed dividend and divisor, and converts each to magnitude by issuing one-cycle requests to the complement unit. It runs an 8-iteration restoring divide on the magnitudes, then re-applies signs. It sits between the top-level operand registers and the divide datapath, and owns the complement unit's control inputs while busy.

---
 rtl/signed_div_sequencer_pkg.sv | 20 ++
 rtl/signed_div_sequencer_step.sv | 21 ++
 rtl/signed_div_sequencer.sv | 128 ++++++++++++
 tb/tb_signed_div_sequencer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/signed_div_sequencer_pkg.sv
// Shared definitions for the signed divide sequencer and its iteration step.
package signed_div_sequencer_pkg;

  localparam int          DW          = 8;
  localparam int          ITERS       = 8;
  localparam logic [7:0]  OVF_OPERAND = 8'h80;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ABS_A,
    S_WAIT_A,
    S_ABS_B,
    S_WAIT_B,
    S_CHECK,
    S_DIV,
    S_SIGN,
    S_DONE
  } state_t;

endpackage

// File: rtl/signed_div_sequencer_step.sv
// One restoring-division iteration on unsigned magnitudes; purely combinational.
module div_step
  import signed_div_sequencer_pkg::*;
(
  input  logic [DW-1:0] rem,
  input  logic [DW-1:0] q,
  input  logic [DW-1:0] mag_b,
  output logic [DW-1:0] rem_next,
  output logic [DW-1:0] q_next
);

  logic [DW-1:0] rem_shifted;
  logic [DW:0]   trial;

  // Magnitudes never exceed 127, so the shifted remainder always fits in DW bits.
  assign rem_shifted = {rem[DW-2:0], q[DW-1]};
  assign trial       = {1'b0, rem_shifted} - {1'b0, mag_b};
  assign rem_next    = trial[DW] ? rem_shifted : trial[DW-1:0];
  assign q_next      = {q[DW-2:0], ~trial[DW]};

endmodule

// File: rtl/signed_div_sequencer.sv
// 8-bit signed divide sequencer: magnitudes via the external complement unit,
// restoring divide on magnitudes, then local sign correction.
module signed_div_sequencer
  import signed_div_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       cu_sel,
  output logic [7:0] cu_a,
  output logic [7:0] cu_b,
  output logic       cu_ci,
  input  logic [7:0] cu_sum
);

  state_t     state_reg, state_next;
  logic [7:0] dividend_reg, divisor_reg;
  logic [7:0] mag_a_reg, mag_b_reg;
  logic [7:0] rem_reg, q_reg;
  logic [7:0] quotient_reg, remainder_reg;
  logic [2:0] count_reg;
  logic       err_reg;
  logic [7:0] step_rem, step_q;
  logic       operand_bad;

  div_step u_step (
    .rem      (rem_reg),
    .q        (q_reg),
    .mag_b    (mag_b_reg),
    .rem_next (step_rem),
    .q_next   (step_q)
  );

  assign operand_bad = (divisor_reg == 8'h00) || (dividend_reg == OVF_OPERAND) ||
                       (divisor_reg == OVF_OPERAND);

  always_comb begin
    state_next = state_reg;
    cu_sel     = 1'b0;
    cu_a       = 8'h00;
    case (state_reg)
      S_IDLE:   if (start) state_next = S_ABS_A;
      S_ABS_A: begin
        cu_sel     = 1'b1;
        cu_a       = dividend_reg;
        state_next = S_WAIT_A;
      end
      S_WAIT_A: state_next = S_ABS_B;
      S_ABS_B: begin
        cu_sel     = 1'b1;
        cu_a       = divisor_reg;
        state_next = S_WAIT_B;
      end
      S_WAIT_B: state_next = S_CHECK;
      S_CHECK:  state_next = operand_bad ? S_DONE : S_DIV;
      S_DIV:    if (count_reg == 3'(ITERS - 1)) state_next = S_SIGN;
      S_SIGN:   state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  assign busy      = (state_reg != S_IDLE);
  assign done      = (state_reg == S_DONE);
  assign err       = err_reg;
  assign quotient  = quotient_reg;
  assign remainder = remainder_reg;
  assign cu_b      = 8'h00;
  assign cu_ci     = cu_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      dividend_reg  <= 8'h00;
      divisor_reg   <= 8'h00;
      mag_a_reg     <= 8'h00;
      mag_b_reg     <= 8'h00;
      rem_reg       <= 8'h00;
      q_reg         <= 8'h00;
      quotient_reg  <= 8'h00;
      remainder_reg <= 8'h00;
      count_reg     <= 3'd0;
      err_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: if (start) begin
          dividend_reg <= dividend;
          divisor_reg  <= divisor;
          err_reg      <= 1'b0;
        end
        // Complement unit has a fixed one-cycle latency; its finish flag is ignored.
        S_WAIT_A: mag_a_reg <= cu_sum;
        S_WAIT_B: mag_b_reg <= cu_sum;
        S_CHECK: begin
          if (operand_bad) begin
            err_reg       <= 1'b1;
            quotient_reg  <= 8'h00;
            remainder_reg <= 8'h00;
          end else begin
            rem_reg   <= 8'h00;
            q_reg     <= mag_a_reg;
            count_reg <= 3'd0;
          end
        end
        S_DIV: begin
          rem_reg   <= step_rem;
          q_reg     <= step_q;
          count_reg <= count_reg + 3'd1;
        end
        // Negation is local: the complement unit passes positive values through.
        S_SIGN: begin
          quotient_reg  <= (dividend_reg[7] ^ divisor_reg[7]) ? (~q_reg + 8'd1) : q_reg;
          remainder_reg <= dividend_reg[7] ? (~rem_reg + 8'd1) : rem_reg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_div_sequencer.sv
// Directed bench for signed_div_sequencer with a behavioural complement unit.
module tb_signed_div_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend, divisor;
  logic       busy, done, err;
  logic [7:0] quotient, remainder;
  logic       cu_sel, cu_ci;
  logic [7:0] cu_a, cu_b;
  logic [7:0] cu_sum = 8'h00;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  signed_div_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .quotient  (quotient),
    .remainder (remainder),
    .cu_sel    (cu_sel),
    .cu_a      (cu_a),
    .cu_b      (cu_b),
    .cu_ci     (cu_ci),
    .cu_sum    (cu_sum)
  );

  // Complement unit: magnitude of negatives, positives passed through, one-cycle latency.
  always @(posedge clk) begin
    if (cu_sel)
      cu_sum <= cu_a[7] ? ({1'b0, ~cu_a[6:0]} + {7'd0, cu_ci}) : cu_a;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er, input logic ee,
                        input int lat);
    int   n = 1;
    int   sel_cnt = 0, sel1 = 0, sel2 = 0, bad = 0;
    logic prev_sel = 1'b0;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    while (!done && n < 40) begin
      if (cu_sel) begin
        sel_cnt++;
        if (sel_cnt == 1) sel1 = n; else sel2 = n;
        if (prev_sel) bad++;
      end
      if (cu_b !== 8'h00 || cu_ci !== cu_sel || busy !== 1'b1) bad++;
      prev_sel = cu_sel;
      @(posedge clk); #1;
      n++;
    end
    check_eq({tag, " latency"}, n, lat);
    check_eq({tag, " quotient"}, quotient, eq);
    check_eq({tag, " remainder"}, remainder, er);
    check_eq({tag, " err"}, err, ee);
    check_eq({tag, " busy@done"}, busy, 1);
    check_eq({tag, " cu_sel count"}, sel_cnt, 2);
    check_eq({tag, " cu_sel slots"}, {sel1[15:0], sel2[15:0]}, {16'd1, 16'd3});
    check_eq({tag, " cu protocol"}, bad, 0);
    @(posedge clk); #1;
    check_eq({tag, " done pulse"}, {done, busy}, 2'b00);
    check_eq({tag, " held quotient"}, quotient, eq);
    check_eq({tag, " held err"}, err, ee);
    $display("op %s: %h / %h -> q=%h r=%h err=%b after %0d cycles",
             tag, a, b, quotient, remainder, err, n);
  endtask

  initial begin
    int busy_bad;
    start = 1'b0; dividend = 8'h00; divisor = 8'h00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset outputs", {quotient, remainder, done, busy, err, cu_sel, cu_ci},
             {8'h00, 8'h00, 5'b00000});
    check_eq("reset cu_a/cu_b", {cu_a, cu_b}, 16'h0000);
    rst = 1'b0;

    run_op("100/7",   8'd100, 8'd7,   8'h0E, 8'h02, 1'b0, 15);
    run_op("-7/2",    8'hF9,  8'h02,  8'hFD, 8'hFF, 1'b0, 15);
    run_op("7/-2",    8'h07,  8'hFE,  8'hFD, 8'h01, 1'b0, 15);
    run_op("-128/3",  8'h80,  8'h03,  8'h00, 8'h00, 1'b1, 6);
    run_op("5/0",     8'h05,  8'h00,  8'h00, 8'h00, 1'b1, 6);
    run_op("100/7 b", 8'd100, 8'd7,   8'h0E, 8'h02, 1'b0, 15);
    run_op("-100/-7", 8'h9C,  8'hF9,  8'h0E, 8'hFE, 1'b0, 15);
    run_op("3/-128",  8'h03,  8'h80,  8'h00, 8'h00, 1'b1, 6);

    // start held high: second accept at T+16, operands changed while busy are ignored
    busy_bad = 0;
    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    @(posedge clk); #1;
    dividend = 8'hF9; divisor = 8'h02;
    for (int n = 1; n <= 31; n++) begin
      if (n != 16 && busy !== 1'b1) busy_bad++;
      if (n == 15) check_eq("b2b first done", {done, quotient, remainder}, {1'b1, 8'h0E, 8'h02});
      if (n == 16) check_eq("b2b idle hold", {busy, done, quotient, remainder}, {2'b00, 8'h0E, 8'h02});
      if (n == 31) begin
        check_eq("b2b second done", {done, quotient, remainder}, {1'b1, 8'hFD, 8'hFF});
        start = 1'b0;
      end
      if (n < 31) begin
        @(posedge clk); #1;
      end
    end
    check_eq("b2b busy span", busy_bad, 0);
    $display("op b2b: 100/7 then -7/2 with start held");
    @(posedge clk); #1;

    // reset during DIV (T+9)
    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("mid-op reset", {busy, done, err, cu_sel, quotient, remainder},
             {4'b0000, 8'h00, 8'h00});
    $display("op reset during DIV: busy=%b q=%h r=%h", busy, quotient, remainder);
    run_op("100/7 post-rst", 8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 15);

    for (int i = 0; i < 12; i++) begin
      int sa, sb;
      sa = int'($urandom_range(0, 254)) - 127;
      do sb = int'($urandom_range(0, 254)) - 127; while (sb == 0);
      run_op($sformatf("rand%0d", i), 8'(sa), 8'(sb), 8'(sa / sb), 8'(sa % sb), 1'b0, 15);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
